// File: rtl/acumulador_bcd_mux_pkg.sv
// Shared types and 7-segment constants for the multi-digit BCD accumulator.
package acumulador_pkg;

   typedef enum logic [1:0] {ENTRY, ADD, SHOW} state_t;

   typedef logic [3:0] bcd_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low {g..a} patterns for digits 0..9.
   localparam logic [6:0] SEG_PAT [10] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

endpackage

// File: rtl/acumulador_bcd_mux_if.sv
// Button/switch inputs and display outputs of the BCD accumulator.
interface acumulador_bcd_mux_if #(
   parameter int DIGITS = 3
);
   localparam int RES_DIGITS = DIGITS + 1;

   logic                   push;
   logic                   guardar;
   logic                   finalizar;
   acumulador_pkg::bcd_t   entrada;
   logic [6:0]             seg;
   logic [RES_DIGITS-1:0]  an;
   logic                   busy;
   logic                   err;

   modport master (
      output push, guardar, finalizar, entrada,
      input  seg, an, busy, err
   );

   modport slave (
      input  push, guardar, finalizar, entrada,
      output seg, an, busy, err
   );

endinterface

// File: rtl/acumulador_bcd_mux_bcd_a_7seg.sv
// Combinational BCD to active-low 7-segment decoder with a blank override.
module bcd_a_7seg
   import acumulador_pkg::*;
(
   input  bcd_t       digit,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (!blank && digit <= 4'd9) begin
         seg = SEG_PAT[digit];
      end
   end

endmodule

// File: rtl/acumulador_bcd_mux.sv
// Multi-digit BCD entry, digit-serial accumulation and multiplexed 7-segment display.
// Optional macro LEADING_ZERO_BLANK_EN blanks digits above the most significant non-zero one.
module acumulador_bcd_mux
   import acumulador_pkg::*;
#(
   parameter int DIGITS         = 3,
   parameter int NUM_OPS        = 2,
   parameter int REFRESH_CYCLES = 50000
) (
   input logic                 clk,
   input logic                 rst,
   acumulador_bcd_mux_if.slave bus
);

   localparam int RES_DIGITS = DIGITS + 1;
   localparam int IDX_W      = $clog2(RES_DIGITS);
   localparam int CNT_W      = $clog2(DIGITS + 1);
   localparam int OPS_W      = $clog2(NUM_OPS + 1);
   localparam int REF_W      = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

   state_t               state_reg, state_next;
   logic                 push_d_reg, guardar_d_reg, finalizar_d_reg;
   logic                 push_ev, guardar_ev, finalizar_ev;
   bcd_t                 operand_reg [DIGITS];
   bcd_t                 acc_reg [RES_DIGITS];
   bcd_t                 op_ext [RES_DIGITS];
   bcd_t                 disp_val [RES_DIGITS];
   logic                 carry_reg;
   logic [IDX_W-1:0]     add_idx_reg;
   logic                 add_last;
   logic [CNT_W-1:0]     digit_cnt_reg;
   logic [OPS_W-1:0]     op_cnt_reg;
   logic                 err_reg;
   logic [4:0]           sum_raw;
   logic                 sum_carry;
   bcd_t                 sum_digit;
   logic [REF_W-1:0]     ref_cnt_reg;
   logic [IDX_W-1:0]     disp_idx_reg;
   logic                 blank_digit;
   logic [6:0]           seg_dec;
   logic [6:0]           seg_reg;
   logic [RES_DIGITS-1:0] an_reg;

   assign push_ev      = bus.push & ~push_d_reg;
   assign guardar_ev   = bus.guardar & ~guardar_d_reg;
   assign finalizar_ev = bus.finalizar & ~finalizar_d_reg;
   assign add_last     = (add_idx_reg == IDX_W'(RES_DIGITS - 1));

   // Operand zero-extended to result width, and the value selected for display.
   generate
      for (genvar gi = 0; gi < RES_DIGITS; gi++) begin : g_ext
         if (gi < DIGITS) begin : g_op
            assign op_ext[gi] = operand_reg[gi];
         end else begin : g_zero
            assign op_ext[gi] = '0;
         end
         assign disp_val[gi] = (state_reg == SHOW) ? acc_reg[gi] : op_ext[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst) state_reg <= ENTRY;
      else      state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ENTRY: begin
            if (finalizar_ev)    state_next = SHOW;
            else if (guardar_ev) state_next = ADD;
         end
         ADD: begin
            if (add_last) state_next = (op_cnt_reg == OPS_W'(NUM_OPS - 1)) ? SHOW : ENTRY;
         end
         SHOW: begin
            if (finalizar_ev) state_next = ENTRY;
         end
         default: state_next = ENTRY;
      endcase
   end

   // One decimal digit of the serial add; +6 mod 16 folds 10..19 back to 0..9.
   always_comb begin
      sum_raw   = {1'b0, acc_reg[add_idx_reg]} + {1'b0, op_ext[add_idx_reg]} + {4'd0, carry_reg};
      sum_carry = (sum_raw > 5'd9);
      sum_digit = sum_carry ? (sum_raw[3:0] + 4'd6) : sum_raw[3:0];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         push_d_reg      <= 1'b0;
         guardar_d_reg   <= 1'b0;
         finalizar_d_reg <= 1'b0;
         operand_reg     <= '{default: '0};
         acc_reg         <= '{default: '0};
         carry_reg       <= 1'b0;
         add_idx_reg     <= '0;
         digit_cnt_reg   <= '0;
         op_cnt_reg      <= '0;
         err_reg         <= 1'b0;
      end else begin
         push_d_reg      <= bus.push;
         guardar_d_reg   <= bus.guardar;
         finalizar_d_reg <= bus.finalizar;
         case (state_reg)
            ENTRY: begin
               if (finalizar_ev) begin
                  operand_reg   <= '{default: '0};
                  digit_cnt_reg <= '0;
                  err_reg       <= 1'b0;
               end else if (guardar_ev) begin
                  add_idx_reg <= '0;
                  carry_reg   <= 1'b0;
               end else if (push_ev) begin
                  if (bus.entrada > 4'd9) begin
                     err_reg <= 1'b1;
                  end else if (digit_cnt_reg < CNT_W'(DIGITS)) begin
                     for (int j = DIGITS - 1; j > 0; j--) operand_reg[j] <= operand_reg[j-1];
                     operand_reg[0] <= bus.entrada;
                     digit_cnt_reg  <= digit_cnt_reg + 1'b1;
                  end
               end
            end
            ADD: begin
               acc_reg[add_idx_reg] <= sum_digit;
               carry_reg            <= sum_carry;
               add_idx_reg          <= add_idx_reg + 1'b1;
               if (add_last) begin
                  op_cnt_reg    <= op_cnt_reg + 1'b1;
                  operand_reg   <= '{default: '0};
                  digit_cnt_reg <= '0;
               end
            end
            SHOW: begin
               if (finalizar_ev) begin
                  acc_reg       <= '{default: '0};
                  op_cnt_reg    <= '0;
                  operand_reg   <= '{default: '0};
                  digit_cnt_reg <= '0;
                  err_reg       <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   // Scan from the top down; a slot is blank if it and everything above it is zero.
   always_comb begin
      logic lit;
      lit         = 1'b0;
      blank_digit = 1'b0;
      for (int j = RES_DIGITS - 1; j >= 0; j--) begin
         lit = lit | (|disp_val[j]);
         if (j != 0 && IDX_W'(j) == disp_idx_reg) blank_digit = ~lit;
      end
   end
`else
   assign blank_digit = 1'b0;
`endif

   bcd_a_7seg u_dec (
      .digit (disp_val[disp_idx_reg]),
      .blank (blank_digit),
      .seg   (seg_dec)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         ref_cnt_reg  <= '0;
         disp_idx_reg <= '0;
         seg_reg      <= SEG_BLANK;
         an_reg       <= '1;
      end else begin
         if (ref_cnt_reg == REF_W'(REFRESH_CYCLES - 1)) begin
            ref_cnt_reg  <= '0;
            disp_idx_reg <= (disp_idx_reg == IDX_W'(RES_DIGITS - 1)) ? '0 : disp_idx_reg + 1'b1;
         end else begin
            ref_cnt_reg <= ref_cnt_reg + 1'b1;
         end
         seg_reg <= seg_dec;
         an_reg  <= ~(RES_DIGITS'(1) << disp_idx_reg);
      end
   end

   assign bus.seg  = seg_reg;
   assign bus.an   = an_reg;
   assign bus.busy = (state_reg == ADD);
   assign bus.err  = err_reg;

endmodule

// File: doc/acumulador_bcd_mux.md
Name: acumulador_bcd_mux

Overview:
Parametrised successor to the single-digit entry/save/sum datapath. Operands are entered digit by digit as multi-digit BCD numbers and committed with guardar. Up to NUM_OPS operands are summed by a digit-serial BCD adder. The current operand or the result is shown on a time-multiplexed multi-digit 7-segment display. It sits between the board's synchronised (already debounced) buttons and switches and the display pins.

Parameters:
DIGITS, 3, BCD digits per operand; legal range 1..8.
NUM_OPS, 2, operands summed before the result is shown automatically; legal range 2..9.
REFRESH_CYCLES, 50000, clk cycles per display digit slot; the bench overrides it to 4.
RES_DIGITS, DIGITS+1, result and display width in digits; localparam, not overridable.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
push  in  1  level; a rising edge enters one digit
guardar  in  1  level; a rising edge commits the operand to the accumulator
finalizar  in  1  level; a rising edge shows the result, or starts a new calculation
entrada  in  4  BCD digit to enter
seg  out  7  segments {g..a}, active-low
an  out  RES_DIGITS  digit enables, one-hot active-low, an[0] is the least significant digit
busy  out  1  high while the serial add runs
err  out  1  sticky flag for an invalid digit; cleared by finalizar or reset

Behaviour:
- rst is sampled only on the clk rising edge; rst==0 resets everything.
- Reset values: state=ENTRY, operand=0, acc=0, op_cnt=0, digit_cnt=0, busy=0, err=0, seg=7'h7F, an=all ones, refresh counter=0.
- Inputs are edge-detected against a 1-cycle delayed copy. Holding a level for any number of cycles gives exactly one event.
- Event priority within one cycle: finalizar > guardar > push.
- ENTRY state, push edge:
  - If entrada > 9: digit ignored, err=1.
  - Else if digit_cnt < DIGITS: operand = operand*10 + entrada (decimal shift left), digit_cnt++.
  - Else (operand already full): digit ignored; err unchanged.
- ENTRY state, guardar edge: go to ADD; busy=1 from the next cycle.
- ADD state:
  - One BCD digit per cycle, least significant digit first, with a decimal-carry register.
  - Runs RES_DIGITS cycles; operand is zero-extended.
  - busy falls on the cycle acc holds the new sum. Latency from the guardar edge to busy falling is RES_DIGITS+1 cycles.
  - Then op_cnt++, operand=0, digit_cnt=0.
  - If op_cnt==NUM_OPS go to SHOW, else return to ENTRY.
  - push, guardar and finalizar edges during ADD are dropped.
- Overflow:
  - The sum can exceed 10^RES_DIGITS-1 only if NUM_OPS>9, which is illegal.
  - Carry out of the top digit is discarded.
- ENTRY state, finalizar edge: go to SHOW, showing acc. The partial operand is discarded, not added.
- SHOW state:
  - push and guardar are ignored.
  - finalizar edge: acc=0, op_cnt=0, operand=0, err=0, go to ENTRY.
- guardar with zero digits entered is legal and adds 0.
- Display:
  - The refresh counter wraps at REFRESH_CYCLES-1, then advances the digit index modulo RES_DIGITS.
  - ENTRY and ADD show operand; SHOW shows acc.
  - seg and an are registered: one cycle after index/value, and both change on the same cycle.
- Reset during ADD aborts the add: acc=0 and busy=0 on the next cycle.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: digits above the most significant non-zero digit are driven blank (seg=7'h7F). A value of 0 shows a single '0' on an[0].
- Undefined: all RES_DIGITS digits are shown, including leading zeros.

Decomposition:
- Package acumulador_pkg holds:
  - the state enum {ENTRY, ADD, SHOW};
  - the bcd_t 4-bit typedef;
  - the SEG_BLANK=7'h7F constant;
  - the 7-segment pattern constant array for 0..9.
- Sub-module bcd_a_7seg: combinational BCD-to-segment decoder using the package patterns, with a blank input. Instantiated once on the muxed digit.

Test Plan:
1. Reset, then push 3,5,7, guardar, then push 4,2,1, guardar -> busy high 4 cycles each time; state SHOW; acc=0778; display slots show 8,7,7,0 (blanked 0 with LEADING_ZERO_BLANK_EN).
2. 999 + 999 -> acc=1998; all four digits lit.
3. Push with entrada=4'd12 -> operand unchanged, err=1; later finalizar -> err=0.
4. push held 5 cycles with entrada=6 -> operand=006; 4th push after 1,2,3 -> operand stays 123.
5. Push 2, then finalizar -> SHOW with acc=0000; second finalizar -> ENTRY, op_cnt=0.
6. rst=0 asserted mid-ADD -> next cycle busy=0, acc=0, seg=7'h7F, an=all ones. Also: guardar and push edges in the same cycle -> only the add occurs.
